// File: rtl/rx_cmd_ctrl_pkg.sv
// rx_cmd_ctrl_pkg: command opcodes, operand addresses and FSM states for the command controller
package rx_cmd_ctrl_pkg;
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;
    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
        S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
    } state_t;
endpackage

// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: parses framed RX command bytes into register/ALU accesses and
// streams the one- or two-byte responses into the TX FIFO.
module rx_cmd_ctrl
    import rx_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [DATA_WIDTH-1:0]   RX_P_Data,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);
    state_t state, state_nx;
    logic [2*DATA_WIDTH-1:0] result, result_nx;
    logic single, single_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wr_data_nx, tx_data_nx;
    logic [3:0] fun_nx;
    logic wr_en_nx, rd_en_nx, alu_en_nx, tx_vld_nx, gate_nx;
    logic is_alu;

    assign is_alu = RX_P_Data == DATA_WIDTH'(CMD_ALU_OP) || RX_P_Data == DATA_WIDTH'(CMD_ALU_NOP);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IDLE;
            result      <= '0;
            single      <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_FUN     <= '0;
            TX_P_DATA   <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            ALU_EN      <= 1'b0;
            TX_D_VLD    <= 1'b0;
            CLK_GATE_EN <= 1'b0;
        end else begin
            state       <= state_nx;
            result      <= result_nx;
            single      <= single_nx;
            Address     <= addr_nx;
            WrData      <= wr_data_nx;
            ALU_FUN     <= fun_nx;
            TX_P_DATA   <= tx_data_nx;
            WrEn        <= wr_en_nx;
            RdEn        <= rd_en_nx;
            ALU_EN      <= alu_en_nx;
            TX_D_VLD    <= tx_vld_nx;
            CLK_GATE_EN <= gate_nx;
        end
    end

    // Strobes default low so each fires for exactly one cycle after its trigger.
    always_comb begin
        state_nx   = state;
        result_nx  = result;
        single_nx  = single;
        addr_nx    = Address;
        wr_data_nx = WrData;
        fun_nx     = ALU_FUN;
        tx_data_nx = TX_P_DATA;
        gate_nx    = CLK_GATE_EN;
        wr_en_nx   = 1'b0;
        rd_en_nx   = 1'b0;
        alu_en_nx  = 1'b0;
        tx_vld_nx  = 1'b0;
        case (state)
            S_IDLE: if (RX_D_VLD) begin
                state_nx = RX_P_Data == DATA_WIDTH'(CMD_WR)      ? S_WR_ADDR :
                           RX_P_Data == DATA_WIDTH'(CMD_RD)      ? S_RD_ADDR :
                           RX_P_Data == DATA_WIDTH'(CMD_ALU_OP)  ? S_ALU_A   :
                           RX_P_Data == DATA_WIDTH'(CMD_ALU_NOP) ? S_ALU_FUN : S_IDLE;
                gate_nx  = is_alu;
            end
            S_WR_ADDR: if (RX_D_VLD) begin
                addr_nx  = RX_P_Data[ADDR_WIDTH-1:0];
                state_nx = S_WR_DATA;
            end
            S_WR_DATA: if (RX_D_VLD) begin
                wr_en_nx   = 1'b1;
                wr_data_nx = RX_P_Data;
                state_nx   = S_IDLE;
            end
            S_RD_ADDR: if (RX_D_VLD) begin
                addr_nx  = RX_P_Data[ADDR_WIDTH-1:0];
                rd_en_nx = 1'b1;
                state_nx = S_RD_WAIT;
            end
            S_RD_WAIT: if (RdData_Valid) begin
                result_nx = {{DATA_WIDTH{1'b0}}, RdData};
                single_nx = 1'b1;
                state_nx  = S_TX_LO;
            end
            S_ALU_A: if (RX_D_VLD) begin
                wr_en_nx   = 1'b1;
                addr_nx    = ADDR_WIDTH'(OPA_ADDR);
                wr_data_nx = RX_P_Data;
                state_nx   = S_ALU_B;
            end
            S_ALU_B: if (RX_D_VLD) begin
                wr_en_nx   = 1'b1;
                addr_nx    = ADDR_WIDTH'(OPB_ADDR);
                wr_data_nx = RX_P_Data;
                state_nx   = S_ALU_FUN;
            end
            S_ALU_FUN: if (RX_D_VLD) begin
                fun_nx    = RX_P_Data[3:0];
                alu_en_nx = 1'b1;
                state_nx  = S_ALU_WAIT;
            end
            S_ALU_WAIT: if (ALU_OUT_VLD) begin
                result_nx = ALU_OUT;
                single_nx = 1'b0;
                state_nx  = S_TX_LO;
            end
            S_TX_LO: if (!FIFO_FULL) begin
                tx_vld_nx  = 1'b1;
                tx_data_nx = result[DATA_WIDTH-1:0];
                state_nx   = single ? S_IDLE : S_TX_HI;
            end
            S_TX_HI: if (!FIFO_FULL) begin
                tx_vld_nx  = 1'b1;
                tx_data_nx = result[2*DATA_WIDTH-1:DATA_WIDTH];
                gate_nx    = 1'b0;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// tb_rx_cmd_ctrl: directed command sequences with hand-computed strobe and data expectations.
module tb_rx_cmd_ctrl;
    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  RX_P_Data = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic [3:0]  Address;
    logic        WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD;
    logic [7:0]  WrData, TX_P_DATA;
    logic [3:0]  ALU_FUN;
    int errors = 0;
    int checks = 0;

    rx_cmd_ctrl dut (
        .CLK(CLK), .Reset(Reset), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
        .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL), .Address(Address),
        .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_Data = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_strobes", {12'h0, WrEn, RdEn, ALU_EN, TX_D_VLD}, 16'h0);
        chk("rst_data", {Address, ALU_FUN, WrData}, 16'h0);
        chk("rst_tx", {7'h0, CLK_GATE_EN, TX_P_DATA}, 16'h0);
        Reset = 1'b1;
        tick();
        // register write, then a read issued back-to-back in the WrEn cycle
        send(8'hAA);
        send(8'h05);
        chk("wr_early", {15'h0, WrEn}, 16'h0);
        send(8'h3C);
        chk("wr_en", {15'h0, WrEn}, 16'h1);
        chk("wr_addr", {12'h0, Address}, 16'h5);
        chk("wr_data", {8'h0, WrData}, 16'h3C);
        chk("wr_no_tx", {15'h0, TX_D_VLD}, 16'h0);
        send(8'hBB);
        chk("wr_en_one", {15'h0, WrEn}, 16'h0);
        send(8'h05);
        chk("rd_en", {15'h0, RdEn}, 16'h1);
        chk("rd_addr", {12'h0, Address}, 16'h5);
        tick();
        chk("rd_en_one", {15'h0, RdEn}, 16'h0);
        tick();
        RdData = 8'h3C;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        chk("rd_tx_wait", {15'h0, TX_D_VLD}, 16'h0);
        tick();
        chk("rd_tx_vld", {15'h0, TX_D_VLD}, 16'h1);
        chk("rd_tx_data", {8'h0, TX_P_DATA}, 16'h3C);
        tick();
        chk("rd_tx_single", {15'h0, TX_D_VLD}, 16'h0);
        chk("rd_no_gate", {15'h0, CLK_GATE_EN}, 16'h0);
        // ALU with operands
        send(8'hCC);
        chk("alu_gate_on", {15'h0, CLK_GATE_EN}, 16'h1);
        send(8'h10);
        chk("opa_wr", {11'h0, WrEn, Address}, 16'h10);
        chk("opa_data", {8'h0, WrData}, 16'h10);
        send(8'h20);
        chk("opb_wr", {11'h0, WrEn, Address}, 16'h11);
        chk("opb_data", {8'h0, WrData}, 16'h20);
        send(8'h00);
        chk("alu_en", {11'h0, ALU_EN, ALU_FUN}, 16'h10);
        chk("alu_no_wr", {15'h0, WrEn}, 16'h0);
        tick();
        chk("alu_en_one", {14'h0, ALU_EN, CLK_GATE_EN}, 16'h1);
        ALU_OUT = 16'h0030;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        tick();
        chk("alu_tx_lo", {6'h0, CLK_GATE_EN, TX_D_VLD, TX_P_DATA}, 16'h0330);
        tick();
        chk("alu_tx_hi", {6'h0, CLK_GATE_EN, TX_D_VLD, TX_P_DATA}, 16'h0100);
        tick();
        chk("alu_tx_done", {14'h0, CLK_GATE_EN, TX_D_VLD}, 16'h0);
        // ALU without operands under FIFO back-pressure
        send(8'hDD);
        chk("nop_gate_on", {15'h0, CLK_GATE_EN}, 16'h1);
        send(8'h02);
        chk("nop_alu_en", {11'h0, ALU_EN, ALU_FUN}, 16'h12);
        chk("nop_no_wr", {15'h0, WrEn}, 16'h0);
        FIFO_FULL = 1'b1;
        ALU_OUT = 16'h1234;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_hold", {15'h0, TX_D_VLD}, 16'h0);
        end
        FIFO_FULL = 1'b0;
        tick();
        chk("nop_tx_lo", {7'h0, TX_D_VLD, TX_P_DATA}, 16'h0134);
        tick();
        chk("nop_tx_hi", {6'h0, CLK_GATE_EN, TX_D_VLD, TX_P_DATA}, 16'h0112);
        tick();
        chk("nop_tx_done", {15'h0, TX_D_VLD}, 16'h0);
        // unknown opcode is discarded
        send(8'h55);
        chk("bad_cmd", {13'h0, WrEn, RdEn, CLK_GATE_EN}, 16'h0);
        send(8'hAA);
        send(8'h01);
        send(8'hFF);
        chk("after_bad_wr", {11'h0, WrEn, Address}, 16'h11);
        chk("after_bad_data", {8'h0, WrData}, 16'hFF);
        // asynchronous reset mid-frame
        send(8'hAA);
        send(8'h03);
        chk("pre_rst_addr", {12'h0, Address}, 16'h3);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_addr", {12'h0, Address}, 16'h0);
        chk("async_rst_data", {8'h0, WrData}, 16'h0);
        tick();
        #2 Reset = 1'b1;
        tick();
        chk("rst_no_wr", {15'h0, WrEn}, 16'h0);
        send(8'hBB);
        send(8'h03);
        chk("post_rst_rd", {11'h0, RdEn, Address}, 16'h13);
        chk("post_rst_no_wr", {15'h0, WrEn}, 16'h0);
        RdData = 8'hA5;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        tick();
        chk("post_rst_tx", {7'h0, TX_D_VLD, TX_P_DATA}, 16'h01A5);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
